// File: rtl/matrix_pkg.sv
// matrix_pkg
// Shared types and constants for the matrix multiplier result path.
//   DATA_W_DEFAULT : default result element width
//   c_idx_e        : element tag, row-major order C11, C12, C21, C22
//   c_elem_t       : signed result element
//   next_ptr()     : drain pointer increment, wraps 3 -> 0
package matrix_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int NUM_SLOTS      = 4;

  typedef enum logic [1:0] {
    C11_IDX = 2'd0,
    C12_IDX = 2'd1,
    C21_IDX = 2'd2,
    C22_IDX = 2'd3
  } c_idx_e;

  typedef logic signed [31:0] c_elem_t;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/matrix_result_drain_if.sv
// matrix_result_drain_if
// Valid/ready element stream leaving the result drain.
//   out_data  : current element, signed, DATA_W bits
//   out_idx   : element tag (matrix_pkg::c_idx_e encoding)
//   out_valid : out_data/out_idx valid
//   out_ready : consumer accepts when out_valid && out_ready
// Modports: master = drain side, slave = consumer side.
interface matrix_result_drain_if #(
  parameter int DATA_W = 32
);

  logic signed [DATA_W-1:0] out_data;
  logic [1:0]               out_idx;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/result_slot.sv
// result_slot
// One buffered result element with its full flag.
//   clk, reset_n : clock, async active-low reset
//   start        : tile restart, empties the slot and ignores a same-cycle strobe
//   strobe, din  : capture request and value from the core
//   take         : slot is moved into the output register this cycle
//   full, dout   : slot state
//   overrun_hit  : strobe arrived while the slot still held an undrained value
module result_slot #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     strobe,
  input  logic                     take,
  input  logic signed [DATA_W-1:0] din,
  output logic                     full,
  output logic signed [DATA_W-1:0] dout,
  output logic                     overrun_hit
);

  logic                     full_q, full_d;
  logic signed [DATA_W-1:0] data_q, data_d;

  always_comb begin
    full_d      = full_q;
    data_d      = data_q;
    overrun_hit = 1'b0;
    if (start) begin
      full_d = 1'b0;
    end else begin
      if (take) full_d = 1'b0;
      if (strobe) begin
        // A slot being drained this cycle is free to accept the new value.
        if (full_q && !take) begin
          overrun_hit = 1'b1;
        end else begin
          data_d = din;
          full_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign dout = data_q;

endmodule

// File: rtl/matrix_result_drain.sv
// matrix_result_drain
// Captures the four 2x2 tile results from the core into per-element slots and
// streams them out in row-major order (C11, C12, C21, C22), one per handshake.
//   clk, reset_n            : clock, async active-low reset
//   start                   : tile restart (clears slots, pointer, out_valid)
//   c11ready..c22ready      : capture strobes; C11..C22 the matching values
//   clr_overrun             : clears the sticky overrun flag
//   out_if (master)         : element stream (data, idx, valid / ready)
//   tile_done               : pulse the cycle after element 3 is accepted
//   overrun                 : sticky, a strobe hit a still-full slot
//   busy                    : any slot full or an element waiting on out_if
module matrix_result_drain
  import matrix_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       c11ready,
  input  logic                       c12ready,
  input  logic                       c21ready,
  input  logic                       c22ready,
  input  logic signed [DATA_W-1:0]   C11,
  input  logic signed [DATA_W-1:0]   C12,
  input  logic signed [DATA_W-1:0]   C21,
  input  logic signed [DATA_W-1:0]   C22,
  input  logic                       clr_overrun,
  matrix_result_drain_if.master      out_if,
  output logic                       tile_done,
  output logic                       overrun,
  output logic                       busy
);

  logic [NUM_SLOTS-1:0]     strobe;
  logic signed [DATA_W-1:0] slot_din  [NUM_SLOTS];
  logic signed [DATA_W-1:0] slot_dout [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]     slot_full;
  logic [NUM_SLOTS-1:0]     slot_ovf;
  logic [NUM_SLOTS-1:0]     take;

  logic [1:0]               ptr_q, ptr_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]               out_idx_q, out_idx_d;
  logic                     out_valid_q, out_valid_d;
  logic                     tile_done_q, tile_done_d;
  logic                     overrun_q, overrun_d;

  logic                     handshake;
  logic                     load;

  assign strobe      = {c22ready, c21ready, c12ready, c11ready};
  assign slot_din[0] = C11;
  assign slot_din[1] = C12;
  assign slot_din[2] = C21;
  assign slot_din[3] = C22;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    result_slot #(.DATA_W(DATA_W)) u_slot (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .strobe      (strobe[i]),
      .take        (take[i]),
      .din         (slot_din[i]),
      .full        (slot_full[i]),
      .dout        (slot_dout[i]),
      .overrun_hit (slot_ovf[i])
    );
  end

  assign handshake = out_valid_q && out_if.out_ready;
  // The output register refills in the same cycle it is emptied, giving
  // one element per cycle when the consumer keeps out_ready high.
  assign load = slot_full[ptr_q] && (!out_valid_q || handshake) && !start;

  always_comb begin
    take        = '0;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    tile_done_d = handshake && (out_idx_q == C22_IDX);
    overrun_d   = overrun_q;

    if (start) begin
      ptr_d       = '0;
      out_valid_d = 1'b0;
    end else if (load) begin
      take[ptr_q] = 1'b1;
      out_data_d  = slot_dout[ptr_q];
      out_idx_d   = ptr_q;
      out_valid_d = 1'b1;
      ptr_d       = next_ptr(ptr_q);
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end

    // A new overrun outranks a same-cycle clear.
    if (|slot_ovf)        overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      tile_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      tile_done_q <= tile_done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_idx   = out_idx_q;
  assign out_if.out_valid = out_valid_q;
  assign tile_done        = tile_done_q;
  assign overrun          = overrun_q;
  assign busy             = (|slot_full) || out_valid_q;

endmodule

// File: tb/tb_matrix_result_drain.sv
module tb_matrix_result_drain;
  import matrix_pkg::*;

  localparam int DW = DATA_W_DEFAULT;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic c11ready, c12ready, c21ready, c22ready;
  logic signed [DW-1:0] C11, C12, C21, C22;
  logic clr_overrun;
  logic tile_done, overrun, busy;

  matrix_result_drain_if #(.DATA_W(DW)) s_if ();

  matrix_result_drain #(.DATA_W(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .c11ready    (c11ready),
    .c12ready    (c12ready),
    .c21ready    (c21ready),
    .c22ready    (c22ready),
    .C11         (C11),
    .C12         (C12),
    .C21         (C21),
    .C22         (C22),
    .clr_overrun (clr_overrun),
    .out_if      (s_if),
    .tile_done   (tile_done),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // stimulus variables
  bit          stb [4];
  logic [DW-1:0] cv [4];
  bit          rdy, start_r, clr_r;

  // reference model: four buffered elements drained in index order
  logic [DW-1:0] m_val [4];
  bit          m_full [4];
  logic [1:0]  m_ptr;
  logic [DW-1:0] m_odata;
  logic [1:0]  m_oidx;
  bit          m_ovalid, m_done, m_ovr;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    c11ready = stb[0]; c12ready = stb[1]; c21ready = stb[2]; c22ready = stb[3];
    C11 = cv[0]; C12 = cv[1]; C21 = cv[2]; C22 = cv[3];
    start = start_r;
    clr_overrun = clr_r;
    s_if.out_ready = rdy;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_val[i]  = '0;
    end
    m_ptr = '0; m_odata = '0; m_oidx = '0;
    m_ovalid = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_step();
    bit hs, ld, set, done_n;
    bit was_full [4];
    logic [1:0] p;
    hs = m_ovalid && rdy;
    done_n = hs && (m_oidx == 2'd3);
    set = 1'b0;
    if (start_r) begin
      for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
      m_ptr = '0;
      m_ovalid = 1'b0;
    end else begin
      p = m_ptr;
      for (int i = 0; i < 4; i++) was_full[i] = m_full[i];
      ld = m_full[p] && (!m_ovalid || hs);
      if (ld) begin
        m_odata = m_val[p];
        m_oidx = p;
        m_ovalid = 1'b1;
        m_full[p] = 1'b0;
        m_ptr = p + 2'd1;
      end else if (hs) begin
        m_ovalid = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (stb[i]) begin
          if (was_full[i] && !(ld && i == int'(p))) set = 1'b1;
          else begin
            m_val[i] = cv[i];
            m_full[i] = 1'b1;
          end
        end
      end
    end
    m_done = done_n;
    if (set) m_ovr = 1'b1;
    else if (clr_r) m_ovr = 1'b0;
  endtask

  task automatic check_all();
    bit m_busy;
    m_busy = m_ovalid || m_full[0] || m_full[1] || m_full[2] || m_full[3];
    chk("out_valid", DW'(s_if.out_valid), DW'(m_ovalid));
    chk("out_data",  s_if.out_data,       m_odata);
    chk("out_idx",   DW'(s_if.out_idx),   DW'(m_oidx));
    chk("tile_done", DW'(tile_done),      DW'(m_done));
    chk("overrun",   DW'(overrun),        DW'(m_ovr));
    chk("busy",      DW'(busy),           DW'(m_busy));
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < 4; i++) stb[i] = 1'b0;
    start_r = 1'b0;
    clr_r = 1'b0;
    drive();
  endtask

  // one clock: apply inputs, advance model, compare after the edge
  task automatic step();
    drive();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    if (tile_done === 1'b1) done_cnt++;
    clear_pulses();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic fill_all(input logic [DW-1:0] a, b, c, d);
    cv[0] = a; cv[1] = b; cv[2] = c; cv[3] = d;
    for (int i = 0; i < 4; i++) stb[i] = 1'b1;
  endtask

  task automatic do_start();
    start_r = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) cv[i] = '0;
    rdy = 1'b0;
    clear_pulses();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // all four strobes in one cycle, consumer always ready
    rdy = 1'b1;
    done_cnt = 0;
    fill_all(32'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFC);
    steps(8);
    chk("tile_done_count", DW'(done_cnt), DW'(1));

    // out-of-order arrival still drains in index order
    cv[3] = 32'h7FFF_FFFF; stb[3] = 1'b1; step();
    cv[2] = 32'h8000_0000; stb[2] = 1'b1; step();
    cv[1] = 32'd5;         stb[1] = 1'b1; step();
    cv[0] = 32'd6;         stb[0] = 1'b1; step();
    steps(7);

    // consumer stalls with idx 0 pending, then releases
    rdy = 1'b0;
    fill_all(32'd11, 32'd12, 32'd13, 32'd14);
    steps(7);
    rdy = 1'b1;
    steps(6);

    // overrun on slot 1 while blocked, then clear
    do_start();
    rdy = 1'b0;
    cv[0] = 32'd20; cv[1] = 32'd21; stb[0] = 1'b1; stb[1] = 1'b1;
    steps(3);
    cv[1] = 32'd9; stb[1] = 1'b1;
    step();
    chk("overrun_set", DW'(overrun), DW'(1));
    rdy = 1'b1;
    steps(4);
    clr_r = 1'b1;
    step();
    chk("overrun_clr", DW'(overrun), DW'(0));

    // strobe into slot 0 in the cycle it is being loaded
    do_start();
    cv[0] = 32'd100; stb[0] = 1'b1; step();
    cv[0] = 32'd200; stb[0] = 1'b1; step();
    chk("same_cycle_no_ovr", DW'(overrun), DW'(0));
    cv[1] = 32'd101; cv[2] = 32'd102; cv[3] = 32'd103;
    stb[1] = 1'b1; stb[2] = 1'b1; stb[3] = 1'b1;
    steps(8);

    // start mid-stream after idx 1 accepted
    do_start();
    fill_all(32'd31, 32'd32, 32'd33, 32'd34);
    steps(4);
    do_start();
    chk("start_valid", DW'(s_if.out_valid), DW'(0));
    chk("start_busy",  DW'(busy),           DW'(0));

    // asynchronous reset mid-stream
    fill_all(32'd41, 32'd42, 32'd43, 32'd44);
    steps(3);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    steps(2);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        stb[i] = ($urandom_range(0, 3) == 0);
        cv[i]  = $urandom;
      end
      start_r = ($urandom_range(0, 63) == 0);
      clr_r   = ($urandom_range(0, 15) == 0);
      step();
    end
    rdy = 1'b1;
    steps(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
